// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Control sequencer for the multicycle RISC-V core. Every instruction
//   walks IF -> ID -> EX -> MEM -> WB. The instruction word is captured into
//   an internal IR on the IF->ID edge, and all strobes are decoded from the
//   state register and IR only.
//
// Optional feature (macro CTRL_MEM_WAIT_EN):
//   When defined, LW/SW hold in MEM, with the strobe asserted, until a cycle
//   with mem_ready = 1. When undefined, mem_ready is ignored.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-low reset
//   instr         instruction word from ROM, sampled at the end of IF
//   Zero          ALU zero flag, sampled at the end of EX
//   mem_ready     data-memory completion (CTRL_MEM_WAIT_EN only)
//   current_state FSM state: IF=0 ID=1 EX=2 MEM=3 WB=4
//   ALUCtrl       ALU operation select
//   ALUSrc        1 = immediate operand B
//   MemRead       data-memory read strobe (MEM, LW)
//   MemWrite      data-memory write strobe (MEM, SW)
//   MemtoReg      1 = write back memory data (WB, LW)
//   RegWrite      register-file write enable (WB)
//   loadPC        PC update enable (WB)
//   PCSrc         1 = branch target, 0 = PC+4
//   illegal       unsupported instruction flag (ID..WB)
module multicycle_ctrl #(
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instr,
   input  logic               Zero,
   input  logic               mem_ready,
   output logic [2:0]         current_state,
   output logic [3:0]         ALUCtrl,
   output logic               ALUSrc,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               MemtoReg,
   output logic               RegWrite,
   output logic               loadPC,
   output logic               PCSrc,
   output logic               illegal
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SRL = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b1001;
   localparam logic [3:0] ALU_SRA = 4'b1010;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   state_t             state_reg, state_next;
   logic [INSTR_W-1:0] ir_reg;
   logic               br_taken_reg;
   // Low until the first edge with rst released, so that the first IF
   // cycle starts on that edge rather than overlapping the reset period.
   logic               run_reg;

   logic [3:0] dec_alu;
   logic       dec_src, dec_ill;
   logic       is_r, is_i, is_lw, is_sw, is_beq;

   // funct3/funct7[5] to ALU op. Bit 30 selects SUB only for register
   // forms (for addi it is an immediate bit); for shifts it picks SRA.
   // sltu is not a supported operation and maps onto SLT.
   function automatic logic [3:0] alu_op(input logic [2:0] f3,
                                         input logic       alt,
                                         input logic       reg_form);
      case (f3)
         3'b000:         alu_op = (alt && reg_form) ? ALU_SUB : ALU_ADD;
         3'b001:         alu_op = ALU_SLL;
         3'b010, 3'b011: alu_op = ALU_SLT;
         3'b100:         alu_op = ALU_XOR;
         3'b101:         alu_op = alt ? ALU_SRA : ALU_SRL;
         3'b110:         alu_op = ALU_OR;
         default:        alu_op = ALU_AND;
      endcase
   endfunction

   // Instruction decode from IR only
   always_comb begin
      dec_alu = ALU_ADD;
      dec_src = 1'b0;
      dec_ill = 1'b0;
      is_r    = 1'b0;
      is_i    = 1'b0;
      is_lw   = 1'b0;
      is_sw   = 1'b0;
      is_beq  = 1'b0;
      case (ir_reg[6:0])
         OP_R: begin
            is_r    = 1'b1;
            dec_alu = alu_op(ir_reg[14:12], ir_reg[30], 1'b1);
         end
         OP_I: begin
            is_i    = 1'b1;
            dec_src = 1'b1;
            dec_alu = alu_op(ir_reg[14:12], ir_reg[30], 1'b0);
         end
         OP_LW: begin
            is_lw   = 1'b1;
            dec_src = 1'b1;
         end
         OP_SW: begin
            is_sw   = 1'b1;
            dec_src = 1'b1;
         end
         OP_BR: begin
            if (ir_reg[14:12] == 3'b000) begin
               is_beq  = 1'b1;
               dec_alu = ALU_SUB;
            end else begin
               dec_ill = 1'b1;
            end
         end
         default: dec_ill = 1'b1;
      endcase
   end

   // Next-state logic
   always_comb begin
      state_next = S_IF;
      case (state_reg)
         S_IF:  state_next = S_ID;
         S_ID:  state_next = S_EX;
         S_EX:  state_next = S_MEM;
`ifdef CTRL_MEM_WAIT_EN
         S_MEM: state_next = ((is_lw || is_sw) && !mem_ready) ? S_MEM : S_WB;
`else
         S_MEM: state_next = S_WB;
`endif
         S_WB:  state_next = S_IF;
         default: state_next = S_IF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= S_IF;
         ir_reg       <= '0;
         br_taken_reg <= 1'b0;
         run_reg      <= 1'b0;
      end else begin
         run_reg <= 1'b1;
         if (run_reg) begin
            state_reg <= state_next;
            if (state_reg == S_IF)
               ir_reg <= instr;
            if (state_reg == S_EX)
               br_taken_reg <= is_beq & Zero;
         end
      end
   end

   // Output decode. During IF the IR still holds the previous instruction,
   // so decoded fields are suppressed until ID.
   always_comb begin
      ALUCtrl  = 4'b0000;
      ALUSrc   = 1'b0;
      illegal  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      loadPC   = 1'b0;
      PCSrc    = 1'b0;
      if (state_reg != S_IF) begin
         ALUCtrl = dec_alu;
         ALUSrc  = dec_src;
         illegal = dec_ill;
      end
      case (state_reg)
         S_MEM: begin
            MemRead  = is_lw;
            MemWrite = is_sw;
         end
         S_WB: begin
            RegWrite = is_r | is_i | is_lw;
            MemtoReg = is_lw;
            loadPC   = 1'b1;
            PCSrc    = br_taken_reg;
         end
         default: ;
      endcase
   end

   assign current_state = state_reg;

   // IR fields (register numbers, immediates) belong to the datapath
`ifdef CTRL_MEM_WAIT_EN
   logic unused_bits;
   assign unused_bits = ^{ir_reg[INSTR_W-1:31], ir_reg[29:15], ir_reg[11:7]};
`else
   logic unused_bits;
   assign unused_bits = ^{ir_reg[INSTR_W-1:31], ir_reg[29:15], ir_reg[11:7], mem_ready};
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: expected per-cycle output records are pushed
// to a queue when an instruction is issued and popped/compared each cycle.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        Zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic [2:0]  current_state;
   logic [3:0]  ALUCtrl;
   logic        ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, loadPC, PCSrc, illegal;

   multicycle_ctrl #(.INSTR_W(32)) dut (
      .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .mem_ready(mem_ready),
      .current_state(current_state), .ALUCtrl(ALUCtrl), .ALUSrc(ALUSrc),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .loadPC(loadPC), .PCSrc(PCSrc), .illegal(illegal)
   );

   always #5 clk = ~clk;

`ifdef CTRL_MEM_WAIT_EN
   localparam int MEM_WAIT_N = 4;
`else
   localparam int MEM_WAIT_N = 1;
`endif

   // {state[14:12], alu[11:8], src[7], mr[6], mw[5], m2r[4], rw[3], lpc[2], pcs[1], ill[0]}
   typedef struct packed {
      logic [14:0] exp;
      logic [14:0] care;
   } rec_t;

   rec_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [14:0] obs();
      return {current_state, ALUCtrl, ALUSrc, MemRead, MemWrite, MemtoReg,
              RegWrite, loadPC, PCSrc, illegal};
   endfunction

   function automatic rec_t mk(input int st, input logic [3:0] alu,
                               input logic src, input logic lw, input logic sw,
                               input logic regw, input logic br, input logic ill,
                               input logic care_alu);
      rec_t       r;
      logic [2:0] s;
      s      = st[2:0];
      r.care = '1;
      if (s == 3'd0) begin
         r.exp = 15'd0;
      end else begin
         r.exp = {s, alu, src, (s == 3'd3) && lw, (s == 3'd3) && sw,
                  (s == 3'd4) && lw, (s == 3'd4) && regw, s == 3'd4,
                  (s == 3'd4) && br, ill};
         if (!care_alu) r.care[11:7] = 5'b0;
      end
      return r;
   endfunction

   task automatic push_instr(input string name, input logic [31:0] ins,
                             input logic [3:0] alu, input logic src,
                             input logic lw, input logic sw, input logic regw,
                             input logic br, input logic ill,
                             input logic care_alu, input int n_mem);
      instr = ins;
      sb.push_back(mk(0, alu, src, lw, sw, regw, br, ill, care_alu));
      sb.push_back(mk(1, alu, src, lw, sw, regw, br, ill, care_alu));
      sb.push_back(mk(2, alu, src, lw, sw, regw, br, ill, care_alu));
      for (int k = 0; k < n_mem; k++)
         sb.push_back(mk(3, alu, src, lw, sw, regw, br, ill, care_alu));
      sb.push_back(mk(4, alu, src, lw, sw, regw, br, ill, care_alu));
      $display("issue %-6s instr=%08h cycles=%0d", name, ins, 4 + n_mem);
   endtask

   task automatic test_reset();
      rst   = 1'b0;
      instr = 32'h00500093;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (obs() !== 15'd0) begin
            errors++;
            $display("FAIL reset_hold cyc%0d got=%h exp=%h", k, obs(), 15'd0);
         end
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      // first instruction after release: state must read 0,1,2,3,4,0
      push_instr("addi", 32'h00500093, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1);
      for (int i = 0; sb.size() > 0; i++) begin
         rec_t r;
         mem_ready = 1'b0;
         r = sb.pop_front();
         checks++;
         if ((obs() & r.care) !== (r.exp & r.care)) begin
            errors++;
            $display("FAIL reset_seq cyc%0d got=%h exp=%h", i, obs(), r.exp);
         end
         @(negedge clk);
      end
      checks++;
      if (current_state !== 3'd0 || loadPC !== 1'b0) begin
         errors++;
         $display("FAIL reset_wrap got state=%0d lpc=%b exp state=0 lpc=0", current_state, loadPC);
      end
   endtask

   task automatic test_alu();
      logic [31:0] ins_t [10] = '{32'h00500093, 32'h402081B3, 32'h0020F1B3, 32'h0020E1B3,
                                  32'h0020A1B3, 32'h4020D1B3, 32'h00309093, 32'h0030D093,
                                  32'h4030D093, 32'hFFF0C113};
      logic [3:0]  alu_t [10] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111,
                                  4'b1010, 4'b1001, 4'b1000, 4'b1010, 4'b0101};
      logic        src_t [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int t = 0; t < 10; t++) begin
         push_instr("alu", ins_t[t], alu_t[t], src_t[t], 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1);
         for (int i = 0; sb.size() > 0; i++) begin
            rec_t r;
            mem_ready = 1'b0;   // non-memory instructions must never stall
            r = sb.pop_front();
            checks++;
            if ((obs() & r.care) !== (r.exp & r.care)) begin
               errors++;
               $display("FAIL alu_%08h cyc%0d got=%h exp=%h", ins_t[t], i, obs(), r.exp);
            end
            @(negedge clk);
         end
      end
      // addi with immediate bit 30 set must still be ADD
      push_instr("addi-n", 32'hC0000093, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1);
      for (int i = 0; sb.size() > 0; i++) begin
         rec_t r;
         mem_ready = 1'b1;
         r = sb.pop_front();
         checks++;
         if ((obs() & r.care) !== (r.exp & r.care)) begin
            errors++;
            $display("FAIL addi_neg cyc%0d got=%h exp=%h", i, obs(), r.exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_mem();
      logic [31:0] ins_t [2] = '{32'h00802283, 32'h00502623};
      for (int t = 0; t < 2; t++) begin
         push_instr(t == 0 ? "lw" : "sw", ins_t[t], 4'b0010, 1'b1, t == 0, t == 1,
                    t == 0, 1'b0, 1'b0, 1'b1, MEM_WAIT_N);
         for (int i = 0; sb.size() > 0; i++) begin
            rec_t r;
            mem_ready = (i >= 6);   // low for the first three MEM cycles
            r = sb.pop_front();
            checks++;
            if ((obs() & r.care) !== (r.exp & r.care)) begin
               errors++;
               $display("FAIL mem_%s cyc%0d got=%h exp=%h", t == 0 ? "lw" : "sw", i, obs(), r.exp);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_branch();
      for (int t = 0; t < 2; t++) begin
         logic z;
         z = (t == 0);
         push_instr("beq", 32'h00000463, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, z, 1'b0, 1'b1, 1);
         for (int i = 0; sb.size() > 0; i++) begin
            rec_t r;
            mem_ready = 1'b1;
            Zero = (i == 2) ? z : ~z;   // Zero only meaningful during EX
            r = sb.pop_front();
            checks++;
            if ((obs() & r.care) !== (r.exp & r.care)) begin
               errors++;
               $display("FAIL beq_z%0d cyc%0d got=%h exp=%h", z, i, obs(), r.exp);
            end
            @(negedge clk);
         end
      end
      Zero = 1'b0;
   endtask

   task automatic test_illegal();
      logic [31:0] ins_t [2] = '{32'hFFFFFFFF, 32'h00001463};
      for (int t = 0; t < 2; t++) begin
         push_instr("illeg", ins_t[t], 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
         for (int i = 0; sb.size() > 0; i++) begin
            rec_t r;
            mem_ready = 1'b1;
            Zero = 1'b1;   // a taken-looking branch must still give PCSrc = 0
            r = sb.pop_front();
            checks++;
            if ((obs() & r.care) !== (r.exp & r.care)) begin
               errors++;
               $display("FAIL illegal_%08h cyc%0d got=%h exp=%h", ins_t[t], i, obs(), r.exp);
            end
            @(negedge clk);
         end
      end
      Zero = 1'b0;
   endtask

   task automatic test_reset_mid_mem();
      push_instr("lw-rst", 32'h00802283, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, MEM_WAIT_N);
      for (int i = 0; i < 4; i++) begin
         rec_t r;
         mem_ready = 1'b0;
         r = sb.pop_front();
         checks++;
         if ((obs() & r.care) !== (r.exp & r.care)) begin
            errors++;
            $display("FAIL rst_mem cyc%0d got=%h exp=%h", i, obs(), r.exp);
         end
         if (i == 3) rst = 1'b0;   // assert reset while LW is in MEM
         @(negedge clk);
      end
      sb.delete();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs() !== 15'd0) begin
            errors++;
            $display("FAIL rst_mem_after cyc%0d got=%h exp=%h", k, obs(), 15'd0);
         end
         if (k == 1) rst = 1'b1;
         @(negedge clk);
      end
      // recovery: a full instruction runs normally after release
      push_instr("addi", 32'h00500093, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1);
      for (int i = 0; sb.size() > 0; i++) begin
         rec_t r;
         mem_ready = 1'b1;
         r = sb.pop_front();
         checks++;
         if ((obs() & r.care) !== (r.exp & r.care)) begin
            errors++;
            $display("FAIL rst_recover cyc%0d got=%h exp=%h", i, obs(), r.exp);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mem();
      test_branch();
      test_illegal();
      test_reset_mid_mem();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
